j1_uart_io: RTL and testbench

// - UART peripheral on the j1 core's IO bus (io_rd/io_wr/io_addr/io_dout/io_din), directly downstream of the CPU.
// - Serialises bytes written by the CPU and buffers received bytes in an RX FIFO.
// - Exposes a flags register and drives the CPU's level-sensitive interrupt_request input.

---
 rtl/j1_uart_io.sv | 199 +++++++++++++++++++
 tb/tb_j1_uart_io.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/j1_uart_io.sv
// UART peripheral for the j1 IO bus: byte TX, RX FIFO, flags register and level IRQ.
// Optional build macro UART_IRQ_EN adds the IRQ mask register and registered irq output.
module j1_uart_io #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] ADDR_DATA    = 16'h1000,
    parameter logic [15:0] ADDR_FLAGS   = 16'h2000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        irq,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic sel_data, sel_flags;
    assign sel_data  = |(io_addr & ADDR_DATA);
    assign sel_flags = |(io_addr & ADDR_FLAGS);

    logic unused_dout;
    assign unused_dout = &{1'b0, io_dout[15:8]};

    // ---------------- transmitter ----------------
    uart_state_t   tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_ready, tx_start, tx_tick;

    assign tx_ready = (tx_state == S_IDLE);
    assign tx_start = io_wr & sel_data & tx_ready;
    assign tx_tick  = (tx_cnt == BIT_END);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (tx_start) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) tx_state <= S_IDLE;
        else         tx_state <= tx_next;

    // uart_tx is updated on the edge that leaves each bit, so every bit lasts exactly one bit period
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_cnt <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                S_IDLE: if (tx_start) begin
                    tx_shift <= io_dout[7:0];
                    tx_bit   <= '0;
                    uart_tx  <= 1'b0;
                end
                S_START: if (tx_tick) uart_tx <= tx_shift[0];
                S_DATA: if (tx_tick) begin
                    if (tx_bit == 3'd7) uart_tx <= 1'b1;
                    else begin
                        uart_tx  <= tx_shift[1];
                        tx_shift <= tx_shift >> 1;
                    end
                    tx_bit <= tx_bit + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- receiver ----------------
    uart_state_t   rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_fall, rx_half, rx_tick, rx_push, rx_ferr;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_half = (rx_cnt == HALF_END);
    assign rx_tick = (rx_cnt == BIT_END);
    assign rx_push = (rx_state == S_STOP) & rx_tick & rx_s2;
    assign rx_ferr = (rx_state == S_STOP) & rx_tick & ~rx_s2;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_half) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) rx_state <= S_IDLE;
        else         rx_state <= rx_next;

    // counter restarts at mid-start so later samples land mid-bit
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick)
                       ? '0 : rx_cnt + 1'b1;
            if (rx_state == S_START && rx_half) rx_bit <= '0;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- RX FIFO and flags ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          empty, full, do_push, do_pop, overrun, frame_err, flags_rd;
    logic [15:0]   flags, rd_data;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_push  = rx_push & ~full;
    assign do_pop   = io_rd & sel_data & ~empty;
    assign flags_rd = io_rd & sel_flags;
    assign flags    = {11'b0, frame_err, overrun, full, ~empty, tx_ready};
    assign rd_data  = empty ? 16'h0000 : {8'h00, fifo_mem[rptr]};

    always_ff @(posedge clk)
        if (do_push) fifo_mem[wptr] <= rx_shift;

    // a new error on the same edge as a flags read stays set so it is not lost
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            io_din    <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            overrun   <= (rx_push & full) | (overrun & ~flags_rd);
            frame_err <= rx_ferr | (frame_err & ~flags_rd);
            if (io_rd)
                io_din <= (sel_data ? rd_data : 16'h0000) | (sel_flags ? flags : 16'h0000);
        end
    end

`ifdef UART_IRQ_EN
    logic irq_mask;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (io_wr & sel_flags) irq_mask <= io_dout[0];
            irq <= irq_mask & ~empty;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_j1_uart_io.sv
// Randomized bench for j1_uart_io against a queue-based model of the FIFO and flags.
module tb_j1_uart_io;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0, resetq = 1'b0, io_rd = 1'b0, io_wr = 1'b0, uart_rx = 1'b1;
    logic [15:0] io_addr = 16'h0, io_dout = 16'h0;
    logic [15:0] io_din;
    logic        irq, uart_tx;

    j1_uart_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
                 .ADDR_DATA(16'h1000), .ADDR_FLAGS(16'h2000)) dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(io_din), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [7:0] m_q[$];
    logic m_ovr = 1'b0, m_ferr = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_flags(input bit tx_idle);
        return {11'b0, m_ferr, m_ovr, m_q.size() == DEPTH, m_q.size() != 0, tx_idle};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [15:0] d);
        io_addr = a; io_dout = d; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [15:0] d);
        io_addr = a; io_rd = 1'b1;
        @(negedge clk);
        io_rd = 1'b0;
        d = io_din;
    endtask

    task automatic rd_check(input logic [15:0] a, input bit tx_idle, input string tag);
        logic [15:0] exp, got;
        exp = 16'h0;
        if ((a & 16'h1000) != 0 && m_q.size() != 0) exp |= {8'h00, m_q[0]};
        if ((a & 16'h2000) != 0) exp |= m_flags(tx_idle);
        io_read(a, got);
        chk(tag, got, exp);
        if ((a & 16'h1000) != 0 && m_q.size() != 0) void'(m_q.pop_front());
        if ((a & 16'h2000) != 0) begin m_ovr = 1'b0; m_ferr = 1'b0; end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; tick(CPB); end
        uart_rx = stop; tick(CPB);
        uart_rx = 1'b1; tick(2);
        if (!stop) m_ferr = 1'b1;
        else if (m_q.size() == DEPTH) m_ovr = 1'b1;
        else m_q.push_back(b);
    endtask

    task automatic rx_glitch();
        uart_rx = 1'b0; tick(1);
        uart_rx = 1'b1; tick(8);
    endtask

    // frame on the wire: start, 8 data LSB first, stop; a second write mid-frame must be ignored
    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] exp_bits, got_bits;
        exp_bits = {1'b1, b, 1'b0};
        got_bits = '0;
        io_write(16'h1000, {8'h01, b});
        fork
            begin
                tick(1);
                for (int k = 0; k < 10; k++) begin
                    got_bits[k] = uart_tx;
                    if (k < 9) tick(CPB);
                end
            end
            begin
                tick(5);
                rd_check(16'h2000, 1'b0, "tx_busy_flags");
                tick(5);
                io_write(16'h1000, 16'h00AA);
            end
        join
        for (int k = 0; k < 10; k++) chk($sformatf("tx_%02h_bit%0d", b, k), 16'(got_bits[k]), 16'(exp_bits[k]));
        tick(3);
        rd_check(16'h2000, 1'b1, "tx_done_flags");
        tick(4);
        chk("tx_idle_line", 16'(uart_tx), 16'h1);
    endtask

    logic [15:0] addrs [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h0000};

    initial begin
        tick(3);
        chk("rst_uart_tx", 16'(uart_tx), 16'h1);
        chk("rst_io_din", io_din, 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        resetq = 1'b1;
        tick(2);
        rd_check(16'h2000, 1'b1, "flags_after_reset");

        tx_frame(8'h55);
        repeat (2) tx_frame(8'($urandom));

        rx_frame(8'hA3, 1'b1);
        rd_check(16'h2000, 1'b1, "rx_a3_flags");
        rd_check(16'h1000, 1'b1, "rx_a3_data");
        tick(3);
        chk("io_din_hold", io_din, 16'h00A3);
        rd_check(16'h2000, 1'b1, "rx_a3_flags_after");
        rd_check(16'h1000, 1'b1, "rx_empty_data");

        for (int i = 1; i <= 9; i++) rx_frame(8'(i), 1'b1);
        rd_check(16'h2000, 1'b1, "ovf_flags");
        rd_check(16'h2000, 1'b1, "ovf_flags_cleared");
        for (int i = 0; i < 8; i++) rd_check(16'h1000, 1'b1, $sformatf("ovf_data%0d", i));
        rd_check(16'h2000, 1'b1, "ovf_drained_flags");

        rx_frame(8'h5A, 1'b0);
        rd_check(16'h2000, 1'b1, "ferr_flags");
        rd_check(16'h2000, 1'b1, "ferr_cleared");
        rd_check(16'h1000, 1'b1, "ferr_no_data");
        rx_glitch();
        rd_check(16'h2000, 1'b1, "glitch_flags");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 10);
            for (int f = 0; f < n; f++) begin
                if ($urandom_range(0, 4) == 0) rx_glitch();
                rx_frame(8'($urandom), ($urandom_range(0, 5) != 0));
            end
            for (int j = 0; j < 12; j++)
                rd_check(addrs[$urandom_range(0, 3)], 1'b1, $sformatf("rand_r%0d_rd%0d", r, j));
        end

        while (m_q.size() != 0) rd_check(16'h1000, 1'b1, "drain");
        rd_check(16'h2000, 1'b1, "drain_flags");

        io_write(16'h2000, 16'h0001);
        tick(1);
        chk("irq_idle", 16'(irq), 16'h0);
        rx_frame(8'h42, 1'b1);
        chk("irq_on_push", 16'(irq), 16'(IRQ_EN));
        rd_check(16'h2000, 1'b1, "irq_flags");
        rd_check(16'h1000, 1'b1, "irq_data");
        tick(1);
        chk("irq_after_pop", 16'(irq), 16'h0);
        io_write(16'h2000, 16'h0000);
        rx_frame(8'h24, 1'b1);
        chk("irq_masked", 16'(irq), 16'h0);
        rd_check(16'h1000, 1'b1, "masked_data");

        rx_frame(8'h7E, 1'b1);
        rd_check(16'h1000, 1'b1, "pre_reset_data");
        io_write(16'h1000, 16'h0000);
        tick(6);
        chk("tx_mid_low", 16'(uart_tx), 16'h0);
        #2 resetq = 1'b0;
        #1;
        chk("async_rst_tx", 16'(uart_tx), 16'h1);
        chk("async_rst_din", io_din, 16'h0);
        chk("async_rst_irq", 16'(irq), 16'h0);
        m_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
        tick(2);
        rd_check(16'h2000, 1'b1, "flags_after_mid_reset");
        tick(10);
        chk("tx_idle_after_reset", 16'(uart_tx), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
